// File: rtl/instruction_queue.sv
// Fetch queue between the icache and decode: owns the fetch PC, issues one
// request at a time and buffers {instr, addr} pairs in a circular FIFO.
//   state | meaning
//   IDLE  | no request outstanding; waiting for room, hold release or redirect
//   REQ   | request for PC presented to icache, waiting for the response
//   DRAIN | redirected while a request was in flight; drop its stale response
module instruction_queue #(
  parameter int          QUEUE_WIDTH  = 3,
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter bit          STOP_ON_CTRL = 1'b1
) (
  input  logic                   clockIn,
  input  logic                   resetIn,
  output logic                   fetchValid,
  output logic [31:0]            fetchAddr,
  input  logic                   instrInValid,
  input  logic [31:0]            instrIn,
  input  logic                   redirectValid,
  input  logic [31:0]            redirectAddr,
  input  logic                   holdFetch,
  output logic                   outValid,
  output logic [31:0]            outInstr,
  output logic [31:0]            outAddr,
  input  logic                   outReady,
  output logic [QUEUE_WIDTH:0]   count,
  output logic                   full,
  output logic                   empty
);

  localparam int DEPTH = 2 ** QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] FULL_COUNT = (QUEUE_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t                 state, stateNext;
  logic [31:0]            pc, pcNext;
  logic                   ctrlPending, ctrlPendingNext;
  logic [QUEUE_WIDTH-1:0] head, tail;
  logic [QUEUE_WIDTH:0]   countNext;
  logic [31:0]            instrMem [DEPTH];
  logic [31:0]            addrMem  [DEPTH];
  logic                   push, pop, flush, isCtrl;

  assign fetchValid = (state == REQ);
  assign fetchAddr  = pc;
  assign outValid   = (count != '0);
  assign outInstr   = instrMem[head];
  assign outAddr    = addrMem[head];
  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);

  assign flush  = redirectValid;
  assign push   = (state == REQ) & instrInValid & ~redirectValid;
  assign pop    = outValid & outReady & ~redirectValid;
  assign isCtrl = STOP_ON_CTRL && ((instrIn[6:0] == 7'b1100011) ||
                                   (instrIn[6:0] == 7'b1101111) ||
                                   (instrIn[6:0] == 7'b1100111));

  assign countNext = flush ? '0
                   : count + {{QUEUE_WIDTH{1'b0}}, push} - {{QUEUE_WIDTH{1'b0}}, pop};

  always_comb begin
    stateNext       = state;
    pcNext          = pc;
    ctrlPendingNext = ctrlPending;
    case (state)
      IDLE: begin
        if (redirectValid) begin
          pcNext          = redirectAddr;
          ctrlPendingNext = 1'b0;
        end else if ((count < FULL_COUNT) && !holdFetch && !ctrlPending) begin
          stateNext = REQ;
        end
      end
      REQ: begin
        if (redirectValid) begin
          pcNext          = redirectAddr;
          ctrlPendingNext = 1'b0;
          stateNext       = instrInValid ? IDLE : DRAIN;
        end else if (instrInValid) begin
          pcNext          = pc + 32'd4;
          ctrlPendingNext = ctrlPending | isCtrl;
          stateNext       = ((countNext < FULL_COUNT) && !holdFetch && !ctrlPendingNext)
                            ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (redirectValid) begin
          pcNext          = redirectAddr;
          ctrlPendingNext = 1'b0;
        end
        if (instrInValid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ctrlPending <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      ctrlPending <= ctrlPendingNext;
      count       <= countNext;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clockIn) begin
    if (push) begin
      instrMem[tail] <= instrIn;
      addrMem[tail]  <= pc;
    end
  end

  always_ff @(posedge clockIn) begin
    if (!resetIn && push) assert (!full);
  end

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_instruction_queue;

  localparam int DEPTH = 8;
  localparam int ST_IDLE = 0, ST_REQ = 1, ST_DRAIN = 2;

  logic        clockIn = 1'b0;
  logic        resetIn, instrInValid, redirectValid, holdFetch, outReady;
  logic [31:0] instrIn, redirectAddr;
  logic        fetchValid, outValid, full, empty;
  logic [31:0] fetchAddr, outInstr, outAddr;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  instruction_queue #(.QUEUE_WIDTH(3), .RESET_PC(32'h0), .STOP_ON_CTRL(1'b1)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .fetchValid(fetchValid), .fetchAddr(fetchAddr),
    .instrInValid(instrInValid), .instrIn(instrIn),
    .redirectValid(redirectValid), .redirectAddr(redirectAddr),
    .holdFetch(holdFetch),
    .outValid(outValid), .outInstr(outInstr), .outAddr(outAddr), .outReady(outReady),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clockIn = ~clockIn;

  // Reference model: a plain queue of {instr, addr} plus PC and fetch phase.
  typedef struct packed {logic [31:0] instr; logic [31:0] addr;} entry_t;
  entry_t      mq[$];
  logic [31:0] mPc;
  int          mState;
  bit          mCtrl;
  bit          modelOn = 0;
  bit          mPop;
  int          mBefore;

  function automatic bit isCtrlOp(input logic [31:0] ins);
    return ins[6:0] == 7'b1100011 || ins[6:0] == 7'b1101111 || ins[6:0] == 7'b1100111;
  endfunction

  always @(posedge clockIn) begin
    if (resetIn) begin
      mq.delete();
      mPc = 32'h0; mState = ST_IDLE; mCtrl = 0; modelOn = 1;
    end else if (modelOn) begin
      mPop = (mq.size() > 0) && outReady && !redirectValid;
      if (redirectValid) begin
        mq.delete();
        mPc = redirectAddr; mCtrl = 0;
        if (mState == ST_REQ) mState = instrInValid ? ST_IDLE : ST_DRAIN;
        else if (mState == ST_DRAIN && instrInValid) mState = ST_IDLE;
      end else begin
        mBefore = mq.size();
        if (mPop) void'(mq.pop_front());
        case (mState)
          ST_IDLE: if (mBefore < DEPTH && !holdFetch && !mCtrl) mState = ST_REQ;
          ST_REQ: if (instrInValid) begin
            mq.push_back({instrIn, mPc});
            mPc = mPc + 4;
            if (isCtrlOp(instrIn)) mCtrl = 1;
            mState = (mq.size() < DEPTH && !holdFetch && !mCtrl) ? ST_REQ : ST_IDLE;
          end
          default: if (instrInValid) mState = ST_IDLE;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    check("m_fetchValid", {31'b0, fetchValid}, {31'b0, mState == ST_REQ});
    check("m_fetchAddr", fetchAddr, mPc);
    check("m_count", {28'b0, count}, mq.size());
    check("m_outValid", {31'b0, outValid}, {31'b0, mq.size() != 0});
    check("m_full", {31'b0, full}, {31'b0, mq.size() == DEPTH});
    check("m_empty", {31'b0, empty}, {31'b0, mq.size() == 0});
    if (mq.size() > 0) begin
      check("m_outInstr", outInstr, mq[0].instr);
      check("m_outAddr", outAddr, mq[0].addr);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [31:0] ins,
                       input logic rv, input logic [31:0] ra, input logic hold,
                       input logic rdy);
    resetIn = rst; instrInValid = iv; instrIn = ins;
    redirectValid = rv; redirectAddr = ra; holdFetch = hold; outReady = rdy;
  endtask

  task automatic step();
    @(posedge clockIn);
    @(negedge clockIn);
    if (modelOn) compareModel();
  endtask

  function automatic logic [31:0] mkInstr(input logic [31:0] addr);
    return (addr << 7) | 32'h13;
  endfunction

  typedef struct {
    logic rst; logic iv; logic [31:0] instr; logic rv; logic [31:0] ra; logic rdy;
    logic eFv; logic [31:0] eFa; int eCnt; logic eOv; logic [31:0] eOa;
  } vec_t;
  vec_t vecs[10];

  task automatic resetAndStart(input logic rdy);
    drive(1, 0, 0, 0, 0, 0, rdy); step();
    drive(0, 0, 0, 0, 0, 0, rdy); step();
  endtask

  initial begin
    logic [31:0] r;
    drive(1, 0, 0, 0, 0, 0, 1);

    //          rst iv instr      rv ra        rdy fv fa        cnt ov oa
    vecs[0] = '{1, 0, 32'h0,     0, 32'h0,   1,  0, 32'h0,   0,  0, 32'h0};
    vecs[1] = '{0, 0, 32'h0,     0, 32'h0,   1,  1, 32'h0,   0,  0, 32'h0};
    vecs[2] = '{0, 1, 32'h13,    0, 32'h0,   1,  1, 32'h4,   1,  1, 32'h0};
    vecs[3] = '{0, 0, 32'h0,     0, 32'h0,   1,  1, 32'h4,   0,  0, 32'h0};
    vecs[4] = '{0, 1, 32'h93,    0, 32'h0,   1,  1, 32'h8,   1,  1, 32'h4};
    vecs[5] = '{0, 0, 32'h0,     0, 32'h0,   1,  1, 32'h8,   0,  0, 32'h0};
    vecs[6] = '{0, 0, 32'h0,     1, 32'h100, 1,  0, 32'h100, 0,  0, 32'h0};
    vecs[7] = '{0, 1, 32'h6f,    0, 32'h0,   1,  0, 32'h100, 0,  0, 32'h0};
    vecs[8] = '{0, 0, 32'h0,     0, 32'h0,   1,  1, 32'h100, 0,  0, 32'h0};
    vecs[9] = '{0, 1, 32'h113,   0, 32'h0,   1,  1, 32'h104, 1,  1, 32'h100};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].instr, vecs[i].rv, vecs[i].ra, 0, vecs[i].rdy);
      step();
      check($sformatf("v%0d_fetchValid", i), {31'b0, fetchValid}, {31'b0, vecs[i].eFv});
      check($sformatf("v%0d_fetchAddr", i), fetchAddr, vecs[i].eFa);
      check($sformatf("v%0d_count", i), {28'b0, count}, vecs[i].eCnt);
      check($sformatf("v%0d_outValid", i), {31'b0, outValid}, {31'b0, vecs[i].eOv});
      if (vecs[i].eOv) check($sformatf("v%0d_outAddr", i), outAddr, vecs[i].eOa);
    end

    // Fill to full with decode stalled, then a single pop reopens fetch at 0x20.
    resetAndStart(0);
    check("fill_empty0", {31'b0, empty}, 1);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, mkInstr(4 * i), 0, 0, 0, 0); step();
    end
    check("fill_count", {28'b0, count}, 8);
    check("fill_full", {31'b0, full}, 1);
    check("fill_fetchValid", {31'b0, fetchValid}, 0);
    check("fill_head", outAddr, 32'h0);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    check("pop_count", {28'b0, count}, 7);
    check("pop_full", {31'b0, full}, 0);
    drive(0, 0, 0, 0, 0, 0, 0); step();
    check("refetch_valid", {31'b0, fetchValid}, 1);
    check("refetch_addr", fetchAddr, 32'h20);

    // Redirect coinciding with a response and a pop at count 3.
    resetAndStart(0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, mkInstr(4 * i), 0, 0, 0, 0); step();
    end
    check("rd_pre_count", {28'b0, count}, 3);
    drive(0, 1, mkInstr(32'hC), 1, 32'h200, 0, 1); step();
    check("rd_count", {28'b0, count}, 0);
    check("rd_fetchValid", {31'b0, fetchValid}, 0);
    check("rd_fetchAddr", fetchAddr, 32'h200);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    check("rd_next_valid", {31'b0, fetchValid}, 1);
    check("rd_next_addr", fetchAddr, 32'h200);

    // JAL at 0x10 halts fetch until a redirect.
    resetAndStart(1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, mkInstr(4 * i), 0, 0, 0, 1); step();
    end
    drive(0, 1, 32'h0000006F, 0, 0, 0, 1); step();
    check("jal_halt_addr", fetchAddr, 32'h14);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1); step();
      check("jal_halted", {31'b0, fetchValid}, 0);
    end
    drive(0, 0, 0, 1, 32'h40, 0, 1); step();
    check("jal_redir_addr", fetchAddr, 32'h40);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    check("jal_resume_valid", {31'b0, fetchValid}, 1);
    check("jal_resume_addr", fetchAddr, 32'h40);

    // Steady push+pop at count 3, pointers wrap several times.
    resetAndStart(0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, mkInstr(4 * i), 0, 0, 0, 0); step();
    end
    for (int k = 0; k < 20; k++) begin
      drive(0, 1, mkInstr(4 * (k + 3)), 0, 0, 0, 1); step();
      check("steady_count", {28'b0, count}, 3);
      check("steady_addr", outAddr, 4 * (k + 1));
      check("steady_instr", outInstr, mkInstr(4 * (k + 1)));
    end

    // Randomized traffic against the model.
    resetAndStart(1);
    for (int n = 0; n < 4000; n++) begin
      r = $urandom;
      drive(0,
            (mState != ST_IDLE) && ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) == 0) ? {r[31:7], 7'b1101111}
            : ($urandom_range(0, 9) == 0) ? {r[31:7], 7'b1100011} : {r[31:7], 7'h13},
            $urandom_range(0, 29) == 0,
            {$urandom_range(0, 32'hFFFF), 2'b00},
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
